// File: rtl/adder4_arbiter_if.sv
`default_nettype none
// ============================================================================
// adder4_arbiter_if : request/response bundle for the shared 4-bit adder.
// Optional a_sub/b_sub under ADDER4_ARB_SUB_EN.  Rev 1.0
// ============================================================================
interface adder4_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_n1;
    logic [WIDTH-1:0] a_n2;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_n1;
    logic [WIDTH-1:0] b_n2;
`ifdef ADDER4_ARB_SUB_EN
    logic             a_sub;
    logic             b_sub;
`endif
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] result;
    logic             co;
    logic             overflow;

    modport slave (
        input  a_valid, a_n1, a_n2, b_valid, b_n1, b_n2, rsp_ready,
`ifdef ADDER4_ARB_SUB_EN
        input  a_sub, b_sub,
`endif
        output a_ready, b_ready, rsp_valid, rsp_id, result, co, overflow
    );

    modport master (
        output a_valid, a_n1, a_n2, b_valid, b_n1, b_n2, rsp_ready,
`ifdef ADDER4_ARB_SUB_EN
        output a_sub, b_sub,
`endif
        input  a_ready, b_ready, rsp_valid, rsp_id, result, co, overflow
    );
endinterface
`default_nettype wire

// File: rtl/adder4_arbiter.sv
`default_nettype none
// ============================================================================
// adder4_arbiter : round-robin arbiter sharing one adder between requesters A/B.
// ADDER4_ARB_SUB_EN enables per-request subtract.  Rev 1.0
// ============================================================================
module adder4_arbiter #(
    parameter int WIDTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    adder4_arbiter_if.slave   bus
);
    localparam int c_MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_prio;      // 0 = A has priority on a tie, 1 = B
    logic [WIDTH-1:0] r_n1;
    logic [WIDTH-1:0] r_n2;
    logic             r_id;
    logic [WIDTH-1:0] r_result;
    logic             r_co;
    logic             r_ovf;
    logic             r_rsp_id;

    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_rsp_valid;
    logic [WIDTH-1:0] w_n1_sel;
    logic [WIDTH-1:0] w_n2_sel;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;

`ifdef ADDER4_ARB_SUB_EN
    logic             r_op;
    logic             w_op_sel;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_a = bus.a_valid && (!bus.b_valid || !r_prio);
                w_grant_b = bus.b_valid && (!bus.a_valid ||  r_prio);
                if (bus.a_valid || bus.b_valid) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_n1_sel = w_grant_b ? bus.b_n1 : bus.a_n1;
    assign w_n2_sel = w_grant_b ? bus.b_n2 : bus.a_n2;

    // Subtract is add of the inverted operand with carry-in; co then means "no borrow".
`ifdef ADDER4_ARB_SUB_EN
    assign w_op_sel = w_grant_b ? bus.b_sub : bus.a_sub;
    assign w_sum    = {1'b0, r_n1} + {1'b0, (r_op ? ~r_n2 : r_n2)} + {{WIDTH{1'b0}}, r_op};
    assign w_ovf    = ((r_n1[c_MSB] == r_n2[c_MSB]) ^ r_op) && (w_sum[c_MSB] != r_n1[c_MSB]);
`else
    assign w_sum    = {1'b0, r_n1} + {1'b0, r_n2};
    assign w_ovf    = (r_n1[c_MSB] == r_n2[c_MSB]) && (w_sum[c_MSB] != r_n1[c_MSB]);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio   <= 1'b0;
            r_n1     <= '0;
            r_n2     <= '0;
            r_id     <= 1'b0;
            r_result <= '0;
            r_co     <= 1'b0;
            r_ovf    <= 1'b0;
            r_rsp_id <= 1'b0;
`ifdef ADDER4_ARB_SUB_EN
            r_op     <= 1'b0;
`endif
        end else begin
            if (w_grant_a || w_grant_b) begin
                r_n1   <= w_n1_sel;
                r_n2   <= w_n2_sel;
                r_id   <= w_grant_b;
                r_prio <= w_grant_a;
`ifdef ADDER4_ARB_SUB_EN
                r_op   <= w_op_sel;
`endif
            end
            if (r_state == S_EXEC) begin
                r_result <= w_sum[c_MSB:0];
                r_co     <= w_sum[WIDTH];
                r_ovf    <= w_ovf;
                r_rsp_id <= r_id;
            end
        end
    end

    assign bus.a_ready   = w_grant_a;
    assign bus.b_ready   = w_grant_b;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.result    = r_result;
    assign bus.co        = r_co;
    assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adder4_arbiter.sv
`default_nettype none
// ============================================================================
// tb_adder4_arbiter : directed + randomized checks of adder4_arbiter against
// a rule-level reference model.  Rev 1.0
// ============================================================================
module tb_adder4_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic op_a = 1'b0;
    logic op_b = 1'b0;

    always #5 clk = ~clk;

    adder4_arbiter_if #(.WIDTH(4)) bus ();

    adder4_arbiter #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef ADDER4_ARB_SUB_EN
    assign bus.a_sub = op_a;
    assign bus.b_sub = op_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = free, 1 = computing, 2 = response offered.
    int m_phase = 0;
    int m_prio  = 0;
    int m_n1 = 0, m_n2 = 0, m_id = 0, m_op = 0;
    int m_res = 0, m_co = 0, m_ov = 0, m_rid = 0;

    always @(negedge clk) begin : compare
        int ea, eb, sx, sy, v;
        if (rst) begin
            m_phase = 0; m_prio = 0;
            m_res = 0; m_co = 0; m_ov = 0; m_rid = 0;
        end
        ea = (m_phase == 0 && bus.a_valid && (!bus.b_valid || m_prio == 0)) ? 1 : 0;
        eb = (m_phase == 0 && bus.b_valid && (!bus.a_valid || m_prio == 1)) ? 1 : 0;
        chk("a_ready",   int'(bus.a_ready),   ea);
        chk("b_ready",   int'(bus.b_ready),   eb);
        chk("rsp_valid", int'(bus.rsp_valid), (m_phase == 2) ? 1 : 0);
        chk("rsp_id",    int'(bus.rsp_id),    m_rid);
        chk("result",    int'(bus.result),    m_res);
        chk("co",        int'(bus.co),        m_co);
        chk("overflow",  int'(bus.overflow),  m_ov);
        if (!rst) begin
            case (m_phase)
                0: if (ea == 1 || eb == 1) begin
                    m_id    = eb;
                    m_n1    = eb ? int'(bus.b_n1) : int'(bus.a_n1);
                    m_n2    = eb ? int'(bus.b_n2) : int'(bus.a_n2);
                    m_op    = eb ? int'(op_b) : int'(op_a);
                    m_prio  = eb ? 0 : 1;
                    m_phase = 1;
                end
                1: begin
                    sx = (m_n1 >= 8) ? m_n1 - 16 : m_n1;
                    sy = (m_n2 >= 8) ? m_n2 - 16 : m_n2;
                    if (m_op == 0) begin
                        m_res = (m_n1 + m_n2) % 16;
                        m_co  = (m_n1 + m_n2 > 15) ? 1 : 0;
                        v     = sx + sy;
                    end else begin
                        m_res = (m_n1 - m_n2 + 16) % 16;
                        m_co  = (m_n1 >= m_n2) ? 1 : 0;
                        v     = sx - sy;
                    end
                    m_ov    = (v > 7 || v < -8) ? 1 : 0;
                    m_rid   = m_id;
                    m_phase = 2;
                end
                default: if (bus.rsp_ready) m_phase = 0;
            endcase
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    int  grant_log [12];
    logic hs_a, hs_b;

    initial begin
        bus.a_valid = 0; bus.a_n1 = 0; bus.a_n2 = 0;
        bus.b_valid = 0; bus.b_n1 = 0; bus.b_n2 = 0;
        bus.rsp_ready = 1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset state
        @(negedge clk);
        chk("reset_result", int'(bus.result), 0);
        chk("reset_rsp_valid", int'(bus.rsp_valid), 0);

        // Single add on A: 0111 + 0001
        drive_edge();
        bus.a_valid = 1; bus.a_n1 = 4'b0111; bus.a_n2 = 4'b0001;
        @(negedge clk);
        chk("t1_grant", int'(bus.a_ready), 1);
        drive_edge();
        bus.a_valid = 0;
        @(negedge clk);
        chk("t1_exec_no_rsp", int'(bus.rsp_valid), 0);
        @(negedge clk);
        chk("t1_rsp_valid", int'(bus.rsp_valid), 1);
        chk("t1_result", int'(bus.result), 8);
        chk("t1_co", int'(bus.co), 0);
        chk("t1_ovf", int'(bus.overflow), 1);
        chk("t1_id", int'(bus.rsp_id), 0);

        // Carry wrap on B: 1111 + 0001
        drive_edge();
        bus.b_valid = 1; bus.b_n1 = 4'b1111; bus.b_n2 = 4'b0001;
        @(negedge clk);
        chk("t2_grant", int'(bus.b_ready), 1);
        drive_edge();
        bus.b_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("t2_result", int'(bus.result), 0);
        chk("t2_co", int'(bus.co), 1);
        chk("t2_ovf", int'(bus.overflow), 0);
        chk("t2_id", int'(bus.rsp_id), 1);

        // Contention from reset: grants A,B,A,B every third cycle
        drive_edge();
        rst = 1;
        bus.a_valid = 1; bus.a_n1 = 4'd2; bus.a_n2 = 4'd3;
        bus.b_valid = 1; bus.b_n1 = 4'd9; bus.b_n2 = 4'd9;
        drive_edge();
        rst = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            grant_log[t] = bus.a_ready ? 1 : (bus.b_ready ? 2 : 0);
            if (t % 3 == 2) chk("rr_rsp_id", int'(bus.rsp_id), (t / 3) % 2);
        end
        for (int t = 0; t < 12; t++) begin
            chk("rr_grant", grant_log[t], (t % 3 != 0) ? 0 : (((t / 3) % 2 == 0) ? 1 : 2));
        end

        // Backpressure: hold rsp_ready low for 5 RESP cycles with B waiting
        drive_edge();
        rst = 1;
        bus.a_n1 = 4'd3; bus.a_n2 = 4'd4;
        bus.rsp_ready = 0;
        drive_edge();
        rst = 0;
        @(negedge clk);
        chk("bp_grant_a", int'(bus.a_ready), 1);
        drive_edge();
        bus.a_valid = 0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", int'(bus.rsp_valid), 1);
            chk("bp_result", int'(bus.result), 7);
            chk("bp_no_grant_b", int'(bus.b_ready), 0);
        end
        drive_edge();
        bus.rsp_ready = 1;
        @(negedge clk);
        chk("bp_no_comb_path", int'(bus.b_ready), 0);
        @(negedge clk);
        chk("bp_grant_b", int'(bus.b_ready), 1);
        chk("bp_rsp_dropped", int'(bus.rsp_valid), 0);

        // Reset while B's operation is in EXEC
        drive_edge();
        bus.b_valid = 0;
        #1 rst = 1;
        #1;
        chk("rst_exec_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_exec_result", int'(bus.result), 0);
        chk("rst_exec_co", int'(bus.co), 0);
        chk("rst_exec_ovf", int'(bus.overflow), 0);
        bus.a_valid = 1; bus.b_valid = 1;
        drive_edge();
        rst = 0;
        @(negedge clk);
        chk("rst_tie_a", int'(bus.a_ready), 1);
        chk("rst_tie_not_b", int'(bus.b_ready), 0);
        drive_edge();
        bus.a_valid = 0; bus.b_valid = 0;
        repeat (3) @(negedge clk);

`ifdef ADDER4_ARB_SUB_EN
        // Subtract on A: 0011 - 0101, then 1000 - 0001
        drive_edge();
        bus.a_valid = 1; op_a = 1; bus.a_n1 = 4'b0011; bus.a_n2 = 4'b0101;
        drive_edge();
        bus.a_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("sub1_result", int'(bus.result), 14);
        chk("sub1_co", int'(bus.co), 0);
        chk("sub1_ovf", int'(bus.overflow), 0);
        drive_edge();
        bus.a_valid = 1; bus.a_n1 = 4'b1000; bus.a_n2 = 4'b0001;
        drive_edge();
        bus.a_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("sub2_result", int'(bus.result), 7);
        chk("sub2_co", int'(bus.co), 1);
        chk("sub2_ovf", int'(bus.overflow), 1);
        drive_edge();
        op_a = 0;
`endif

        // Randomized traffic with backpressure, drops and occasional reset
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            hs_a = bus.a_valid && bus.a_ready;
            hs_b = bus.b_valid && bus.b_ready;
            drive_edge();
            rst = ($urandom_range(0, 149) == 0);
            if (hs_a || !bus.a_valid) begin
                bus.a_valid = $urandom_range(0, 1) != 0;
                bus.a_n1    = 4'($urandom_range(0, 15));
                bus.a_n2    = 4'($urandom_range(0, 15));
`ifdef ADDER4_ARB_SUB_EN
                op_a        = $urandom_range(0, 1) != 0;
`endif
            end else if ($urandom_range(0, 7) == 0) begin
                bus.a_valid = 0;
            end
            if (hs_b || !bus.b_valid) begin
                bus.b_valid = $urandom_range(0, 1) != 0;
                bus.b_n1    = 4'($urandom_range(0, 15));
                bus.b_n2    = 4'($urandom_range(0, 15));
`ifdef ADDER4_ARB_SUB_EN
                op_b        = $urandom_range(0, 1) != 0;
`endif
            end else if ($urandom_range(0, 7) == 0) begin
                bus.b_valid = 0;
            end
            bus.rsp_ready = $urandom_range(0, 3) != 0;
        end
        drive_edge();
        rst = 0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/adder4_arbiter.md
# adder4_arbiter

Round-robin arbiter and sequencer that shares one 4-bit adder between two requesters (A, B) in the ALU practical. Each requester presents two 4-bit operands under a valid/ready handshake. The block grants one request at a time, latches the operands, computes the sum with carry-out and signed overflow, and returns the registered result on a single response channel tagged with the requester ID.

## Interface
- `WIDTH`, default 4: operand and result width; all tests use 4.
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `a_valid` in, 1: requester A has an operation pending.
- `a_ready` out, 1: grant to A; the handshake completes when `a_valid && a_ready`.
- `a_n1`, `a_n2` in, WIDTH: A's operands.
- `b_valid` in, 1: requester B has an operation pending.
- `b_ready` out, 1: grant to B.
- `b_n1`, `b_n2` in, WIDTH: B's operands.
- `a_sub`, `b_sub` in, 1: subtract select. Present only with `ADDER4_ARB_SUB_EN`.
- `rsp_valid` out, 1: the response is valid.
- `rsp_ready` in, 1: the consumer accepts the response.
- `rsp_id` out, 1: 0 means A, 1 means B.
- `result` out, WIDTH: sum (or difference), modulo 2^WIDTH.
- `co` out, 1: carry out of the MSB.
- `overflow` out, 1: two's-complement signed overflow.

## Operation
- FSM states and transitions:
  - IDLE: when any valid is high, go to EXEC.
  - EXEC: always go to RESP after one cycle.
  - RESP: when `rsp_ready` is high, go to IDLE; otherwise stay.
- Grants:
  - `a_ready` and `b_ready` are combinational and are asserted only in IDLE. At most one is high in any cycle.
  - The winner is chosen from `a_valid`, `b_valid` and the priority pointer `prio`.
  - If only one requester is valid, it wins.
  - If both are valid, the requester `prio` points at wins.
- On a handshake:
  - Latch n1, n2, the requester ID and the op (if enabled).
  - Set `prio` to the other requester. This is round-robin with no starvation.
- EXEC:
  - Compute `{co, result} = n1 + n2`.
  - `overflow = (n1[MSB] == n2[MSB]) && (result[MSB] != n1[MSB])`.
  - Register `result`, `co`, `overflow` and `rsp_id`.
- RESP:
  - `rsp_valid` is high.
  - `result`, `co`, `overflow` and `rsp_id` stay stable until the `rsp_valid && rsp_ready` handshake.
  - New requests are not granted during EXEC or RESP; requesters hold `valid` and their operands.
- Response outputs keep their last value after the handshake; only `rsp_valid` drops.
- A requester may drop `valid` before it is granted. No grant is issued and nothing is latched for it.
- Reset, including reset mid-operation:
  - state = IDLE, `prio` = A.
  - `rsp_valid` = 0, `result` = 0, `co` = 0, `overflow` = 0, `rsp_id` = 0.
  - Any in-flight operation is discarded.

## Timing
- Handshake in cycle N gives `rsp_valid` high in cycle N+2, provided `rsp_ready` is held high.
- Minimum spacing between grants is 3 cycles (IDLE, EXEC, RESP). Peak throughput is one op per 3 cycles.
- Back-to-back case with both requesters valid and `rsp_ready` held high: grants alternate A, B, A, B, each 3 cycles apart.
- `rsp_valid` deasserts in the cycle after the response handshake. The next grant can occur in that same cycle, since the FSM is back in IDLE.
- No combinational path from `rsp_ready` to `a_ready` or `b_ready` in the same cycle; the grant waits for the IDLE state.

## Configuration
- `ADDER4_ARB_SUB_EN` defined:
  - The `a_sub` and `b_sub` ports exist, and the op bit is latched at grant.
  - When the op bit is 1, EXEC computes `n1 + ~n2 + 1`.
  - `co` = 1 means no borrow.
  - `overflow = (n1[MSB] != n2[MSB]) && (result[MSB] != n1[MSB])`.
- `ADDER4_ARB_SUB_EN` undefined: the ports are absent and every operation is an add.

## Test plan
- Single add, A only: `a_valid`=1, n1=0111, n2=0001, `rsp_ready`=1. Required: `a_ready` high for one cycle; 2 cycles later `result`=1000, `co`=0, `overflow`=1, `rsp_id`=0.
- Carry wrap, B only: n1=1111, n2=0001. Required: `result`=0000, `co`=1, `overflow`=0, `rsp_id`=1.
- Contention: A and B valid continuously from reset, `rsp_ready`=1. Required: grant order A, B, A, B, each 3 cycles apart; `rsp_id` sequence 0, 1, 0, 1.
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` rises. Required: outputs stable, no new grant while B is valid; B is granted in the cycle after `rsp_ready` = 1.
- Reset mid-EXEC: assert `rst` during EXEC. Required: immediately `rsp_valid`=0, `result`=0, `co`=0, `overflow`=0; after release, A wins a tie.
- With `ADDER4_ARB_SUB_EN`: A sub, n1=0011, n2=0101. Required: `result`=1110, `co`=0, `overflow`=0. Then n1=1000, n2=0001: `result`=0111, `overflow`=1.
